// File: rtl/dtree_pkg.sv
// Shared definitions for the decision-tree feature loader.
//
// Contents:
//   DTREE_FEAT_W   default bits per feature byte
//   DTREE_CLASS_W  default width of the tree class output
//   STAT_W         width of each per-class result counter
//   loader_state_e loader FSM states (LOAD, DRAIN, SETTLE, RESULT)
//   stat_sat_inc   saturating increment used by the class counters
package dtree_pkg;

    localparam int DTREE_FEAT_W  = 8;
    localparam int DTREE_CLASS_W = 2;
    localparam int STAT_W        = 16;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2,
        RESULT = 2'd3
    } loader_state_e;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [STAT_W-1:0] stat_sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dtree_class_stats.sv
// Per-class result counters for the feature loader.
//
// One STAT_W-bit saturating counter per class value. The counter selected by
// cls_i advances on every cycle inc_i is high; clr_i zeroes all counters and
// takes priority over a simultaneous increment.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   clr_i        in   clear all counters
//   inc_i        in   count one result of class cls_i
//   cls_i        in   class of the result being counted
//   stats_flat_o out  class c count at [c*STAT_W +: STAT_W]
module dtree_class_stats
    import dtree_pkg::*;
#(
    parameter int CLASS_W = DTREE_CLASS_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr_i,
    input  logic                             inc_i,
    input  logic [CLASS_W-1:0]               cls_i,
    output logic [(1<<CLASS_W)*STAT_W-1:0]   stats_flat_o
);

    localparam int NUM_CLASSES = 1 << CLASS_W;

    logic [STAT_W-1:0] cnt_q [NUM_CLASSES];

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                cnt_q[c] <= '0;
            end
        end else if (inc_i) begin
            cnt_q[cls_i] <= stat_sat_inc(cnt_q[cls_i]);
        end
    end

    always_comb begin
        stats_flat_o = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            stats_flat_o[c*STAT_W +: STAT_W] = cnt_q[c];
        end
    end

endmodule

// File: rtl/dtree_feature_loader.sv
// Stream front end for the combinational decision-tree classifiers.
//
// Feature bytes arrive one per valid/ready beat and are written into dense
// slots of feat_flat, which drives the tree inputs directly. After the last
// byte of a correctly sized frame the loader waits SETTLE_CYCLES for the tree
// to settle, captures cls_in, and presents it on the m_* result port until
// accepted. Frames ending early or running long raise a one-cycle err_len;
// long frames are absorbed up to their s_last beat and produce no result.
//
// Optional feature: define DTREE_CLASS_STATS_EN to enable per-class 16-bit
// saturating result counters on stats_flat (cleared by stats_clr). Without it
// stats_flat reads 0 and stats_clr is ignored; the ports are always present.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   s_valid    in   feature byte valid
//   s_ready    out  loader can accept a byte (LOAD and DRAIN states)
//   s_data     in   feature byte
//   s_last     in   final byte of frame
//   feat_flat  out  slot k at [k*FEAT_W +: FEAT_W], to tree inputs
//   cls_in     in   tree class, combinational on feat_flat
//   m_valid    out  result valid
//   m_ready    in   result accepted
//   m_class    out  captured class
//   err_len    out  one-cycle pulse on frame length error
//   stats_clr  in   clear class counters
//   stats_flat out  class c count at [c*16 +: 16]
module dtree_feature_loader
    import dtree_pkg::*;
#(
    parameter int NUM_FEATURES  = 18,
    parameter int FEAT_W        = DTREE_FEAT_W,
    parameter int CLASS_W       = DTREE_CLASS_W,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [FEAT_W-1:0]                s_data,
    input  logic                             s_last,
    output logic [NUM_FEATURES*FEAT_W-1:0]   feat_flat,
    input  logic [CLASS_W-1:0]               cls_in,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [CLASS_W-1:0]               m_class,
    output logic                             err_len,
    input  logic                             stats_clr,
    output logic [(1<<CLASS_W)*STAT_W-1:0]   stats_flat
);

    localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam int CNT_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_FEATURES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    loader_state_e                   state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [NUM_FEATURES*FEAT_W-1:0]  feat_q, feat_d;
    logic                            m_valid_q, m_valid_d;
    logic [CLASS_W-1:0]              m_class_q, m_class_d;
    logic                            err_q, err_d;
    logic                            beat;

    assign s_ready = (state_q == LOAD) || (state_q == DRAIN);
    assign beat    = s_valid && s_ready;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        feat_d    = feat_q;
        m_valid_d = m_valid_q;
        m_class_d = m_class_q;
        err_d     = 1'b0;

        unique case (state_q)
            LOAD: begin
                if (beat) begin
                    feat_d[idx_q*FEAT_W +: FEAT_W] = s_data;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (s_last) begin
                            state_d = SETTLE;
                            cnt_d   = '0;
                        end else begin
                            // Long frame: flag it now, swallow the rest.
                            err_d   = 1'b1;
                            state_d = DRAIN;
                        end
                    end else if (s_last) begin
                        // Short frame: partial slot contents are left as-is.
                        err_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (beat && s_last) begin
                    state_d = LOAD;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    m_class_d = cls_in;
                    m_valid_d = 1'b1;
                    state_d   = RESULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESULT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOAD;
            idx_q     <= '0;
            cnt_q     <= '0;
            feat_q    <= '0;
            m_valid_q <= 1'b0;
            m_class_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            feat_q    <= feat_d;
            m_valid_q <= m_valid_d;
            m_class_q <= m_class_d;
            err_q     <= err_d;
        end
    end

    assign feat_flat = feat_q;
    assign m_valid   = m_valid_q;
    assign m_class   = m_class_q;
    assign err_len   = err_q;

`ifdef DTREE_CLASS_STATS_EN
    dtree_class_stats #(
        .CLASS_W (CLASS_W)
    ) u_stats (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (stats_clr),
        .inc_i        (m_valid_q && m_ready),
        .cls_i        (m_class_q),
        .stats_flat_o (stats_flat)
    );
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign stats_flat       = '0;
`endif

endmodule
